booth_mul_seq: RTL and testbench
================================

# booth_mul_seq

Parametrised sequential radix-4 Booth multiplier for the CPU's multiply path (MULT/MULTU into HI/LO). It accepts one signed or unsigned WIDTH×WIDTH operation through a valid/ready handshake and iterates two multiplier bits per cycle. It returns the exact 2·WIDTH product through a second valid/ready handshake. A pipeline flush can cancel an operation at any point.

## Interface
- WIDTH, 32, operand width; even, ≥4
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and mode presented
- in_ready  out  1  block accepts operands this cycle
- mul_a  in  WIDTH  multiplicand
- mul_b  in  WIDTH  multiplier
- mul_signed  in  1  1 = two's-complement operands, 0 = unsigned
- cancel  in  1  flush: abort any operation, discard result
- out_valid  out  1  mul_res holds a finished product
- out_ready  in  1  consumer takes the result
- mul_res  out  2·WIDTH  product, registered

## Operation
- States:
  - IDLE: waits for operands.
  - CALC: iterates the Booth recoding.
  - DONE: holds the result until the consumer takes it.
- Accept: occurs when in_valid && in_ready. Latches mul_a and mul_b, sign-extended (mul_signed=1) or zero-extended (0) to WIDTH+2 bits. Clears the accumulator and the iteration counter, sets the Booth bit b[-1]=0, then goes to CALC.
- CALC:
  - Each cycle, recode {b[i+1], b[i], b[i-1]} to a digit in {0, ±A, ±2A}.
  - Add the digit, shifted by i, to the 2·WIDTH+2-bit accumulator; i advances by 2.
  - N = WIDTH/2+1 iterations (17 at WIDTH=32); after the last iteration go to DONE.
- DONE: mul_res = low 2·WIDTH bits of the accumulator; out_valid=1. On out_valid && out_ready, go to IDLE.
- in_ready = !cancel && resetn && (state==IDLE || (state==DONE && out_ready)).
  - Back-to-back: if a new operation is accepted in DONE in the same cycle as the output handshake, go straight to CALC.
- cancel (any state): the next state is IDLE and out_valid falls at the next edge. The pending result is lost and mul_res keeps its old value. cancel overrides a simultaneous in_valid or out handshake: nothing is accepted and no handshake counts.
- Arithmetic: the result is exact for all inputs, with no overflow or saturation.
  - Signed: two's-complement product.
  - Unsigned: unsigned product.
- mul_res changes only on the transition into DONE. It is stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: state IDLE, out_valid 0, mul_res 0, accumulator and counter 0. in_ready is 0 while resetn is low and 1 in the first cycle after release.
- Reset asserted mid-CALC or mid-DONE aborts immediately and asynchronously; the block returns to the reset values.
- Latency without early termination: accept at edge T; CALC during cycles T+1..T+N; out_valid high from cycle T+N+1 (T+18 at WIDTH=32).
- Throughput: one operation per N+1 cycles when out_ready stays high, using the DONE-state back-to-back accept.
- No combinational path from in_valid or mul_a/mul_b to any output. in_ready depends combinationally on cancel and out_ready only.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - After each CALC iteration, the block checks the unconsumed multiplier bits together with the next b[i-1].
  - If these are all equal (all remaining Booth digits are 0), it goes to DONE immediately.
  - Minimum is one CALC cycle. For mul_b ∈ {0, 1, −1 signed}, out_valid is high at T+2.
  - The result is identical to the full iteration.
- Undefined: always N CALC cycles; latency is fixed at N+1.

## Test plan
- Signed 0xFFFFFFFF × 0xFFFFFFFF -> mul_res 0x0000_0000_0000_0001. Unsigned with the same operands -> 0xFFFF_FFFE_0000_0001; out_valid at T+18 (flag off).
- Signed 0x8000_0000 × 0x8000_0000 -> 0x4000_0000_0000_0000. Signed 0x8000_0000 × 0x7FFF_FFFF -> 0xC000_0000_8000_0000.
- out_ready held 0 for 5 cycles after out_valid -> mul_res stable, in_ready 0. Then out_ready=1 with in_valid=1 -> new operation accepted in the same cycle, no idle cycle.
- cancel pulsed in CALC cycle 7 -> out_valid never rises for that operation, in_ready=1 the next cycle. A following 3×5 returns 15.
- resetn dropped mid-CALC -> out_valid=0 and mul_res=0 immediately. After release, 100 random signed/unsigned pairs match the reference product, including WIDTH=8 and WIDTH=16 builds.
- MUL_EARLY_TERM_EN on: mul_b=0 -> 0 at T+2; mul_b=1 -> mul_a at T+2; random operands match the reference product with latency ≤ T+18.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier for the MULT/MULTU path.
// One WIDTH x WIDTH operation (signed or unsigned) is accepted through a
// valid/ready handshake. Two multiplier bits are retired per CALC cycle, and
// the exact 2*WIDTH product is returned through a second valid/ready
// handshake. A cancel input flushes any operation in flight.
//
// Optional feature: define MUL_EARLY_TERM_EN to leave CALC as soon as every
// remaining Booth digit is zero. The result is identical either way.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for operands
// S_CALC | one Booth digit per cycle is added into the accumulator
// S_DONE | mul_res holds the product until the consumer takes it

module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mul_a,
  input  logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_signed,
  input  logic                 cancel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mul_res
);

  // Two guard bits let the unsigned case use the same signed Booth recoding.
  localparam int EXT_W  = WIDTH + 2;
  localparam int ACC_W  = 2 * WIDTH + 2;
  localparam int N_ITER = WIDTH / 2 + 1;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  // The multiplicand is kept pre-shifted by i, so each digit adds in place.
  logic [ACC_W-1:0] a_sh;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] digit;
  logic [ACC_W-1:0] acc_sum;
  // Bit 0 is b[i-1]; bits [2:0] form the current Booth triple.
  logic [EXT_W:0]   b_sh;
  logic [EXT_W:0]   b_shr;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_iter;

  // Handshake signals. in_ready sees only cancel, out_ready and registered state.
  assign in_ready  = !cancel && resetn &&
                     ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);

  // Extend the operands by two bits, with sign or zero fill.
  assign a_ext = mul_signed ? {{2{mul_a[WIDTH-1]}}, mul_a} : {2'b00, mul_a};
  assign b_ext = mul_signed ? {{2{mul_b[WIDTH-1]}}, mul_b} : {2'b00, mul_b};

  // Multiplier window for the next iteration. The shift fills with the top
  // bit, which is already the extended sign (or zero).
  assign b_shr = {{2{b_sh[EXT_W]}}, b_sh[EXT_W:2]};

  // Recode {b[i+1], b[i], b[i-1]} into a digit in {0, +-A, +-2A}.
  always_comb begin
    digit = '0;
    case (b_sh[2:0])
      3'b001, 3'b010: digit = a_sh;
      3'b011:         digit = a_sh << 1;
      3'b100:         digit = -(a_sh << 1);
      3'b101, 3'b110: digit = -a_sh;
      default:        digit = '0;
    endcase
  end

  assign acc_sum = acc + digit;

`ifdef MUL_EARLY_TERM_EN
  logic rest_uniform;
  // If the remaining bits and the next b[i-1] are all equal, every remaining
  // digit is zero and acc_sum is already the final product.
  assign rest_uniform = (&b_shr) || !(|b_shr);
  assign last_iter    = (cnt == CNT_W'(N_ITER - 1)) || rest_uniform;
`else
  assign last_iter    = (cnt == CNT_W'(N_ITER - 1));
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. cancel overrides every handshake.
  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state_nxt = S_CALC;
        end
        S_CALC: begin
          if (last_iter) state_nxt = S_DONE;
        end
        S_DONE: begin
          // Taking a new operand here, in the same cycle as the output
          // handshake, gives back-to-back operation with no idle cycle.
          if (out_ready) state_nxt = accept ? S_CALC : S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: load on accept, then iterate. mul_res is written only on the
  // final iteration, which is the transition into S_DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      mul_res <= '0;
    end else if (accept) begin
      a_sh <= {{(ACC_W - EXT_W){a_ext[EXT_W-1]}}, a_ext};
      b_sh <= {b_ext, 1'b0};
      acc  <= '0;
      cnt  <= '0;
    end else if ((state == S_CALC) && !cancel) begin
      acc  <= acc_sum;
      a_sh <= a_sh << 2;
      b_sh <= b_shr;
      cnt  <= cnt + 1'b1;
      if (last_iter) begin
        mul_res <= acc_sum[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq. It runs directed vectors, the
// multi-cycle corner sequences and random operands on a WIDTH=32 instance.
// Free-running random traffic on WIDTH=8 and WIDTH=16 instances is checked
// against a queue of reference products.
// Pass +define+MUL_EARLY_TERM_EN to check the early-termination build.

module tb_booth_mul_seq;

  localparam int W      = 32;
  localparam int FULL_L = W / 2 + 2;  // out_valid cycle after accept, no early exit

  logic        clk;
  logic        resetn;
  logic        in_valid, in_ready, mul_signed, cancel, out_valid, out_ready;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_res;

  logic        resetn_s;
  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] r16;

  int checks = 0;
  int errors = 0;
  logic small_done = 1'b0;

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .cancel(cancel),
    .out_valid(out_valid), .out_ready(out_ready), .mul_res(mul_res)
  );

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn_s), .in_valid(iv8), .in_ready(ir8),
    .mul_a(a8), .mul_b(b8), .mul_signed(s8), .cancel(1'b0),
    .out_valid(ov8), .out_ready(or8), .mul_res(r8)
  );

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .resetn(resetn_s), .in_valid(iv16), .in_ready(ir16),
    .mul_a(a16), .mul_b(b16), .mul_signed(s16), .cancel(1'b0),
    .out_valid(ov16), .out_ready(or16), .mul_res(r16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend both operands to 64 bits, multiply, keep 2w bits.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input int w);
    logic [63:0] m, ea, eb;
    m  = (64'd1 << w) - 64'd1;
    ea = {32'b0, a} & m;
    eb = {32'b0, b} & m;
    if (s && a[w-1]) ea = ea | ~m;
    if (s && b[w-1]) eb = eb | ~m;
    return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected latency: fixed without early exit; bounded with early exit,
  // and exactly 2 for a trivial multiplier.
  task automatic chk_lat(input string name, input logic [31:0] b, input logic s, input int lat);
`ifdef MUL_EARLY_TERM_EN
    if (b == 32'd0 || b == 32'd1 || (s && b == 32'hFFFF_FFFF))
      chk(name, 64'(lat), 64'd2);
    else
      chk(name, 64'(lat >= 2 && lat <= FULL_L), 64'd1);
`else
    chk(name, 64'(lat), 64'(FULL_L));
`endif
  endtask

  // Wait for out_valid after an accept edge. lat = k means out_valid first
  // seen in cycle T+k.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [63:0] res, output int lat);
    int n;
    mul_a = a; mul_b = b; mul_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    wait_done(lat);
    res = mul_res;
    tick;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [63:0] res, r0;
    logic [31:0] ra, rb;
    logic        rs;
    int          lat;
    logic        seen;

    vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
    vecs[4]  = '{32'd3,         32'd5,         1'b0, 64'd15};
    vecs[5]  = '{32'd0,         32'h1234_5678, 1'b1, 64'd0};
    vecs[6]  = '{32'h1234_5678, 32'd0,         1'b1, 64'd0};
    vecs[7]  = '{32'h1234_5678, 32'd1,         1'b1, 64'h0000_0000_1234_5678};
    vecs[8]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[10] = '{32'hFFFF_FFFF, 32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE};

    resetn = 1'b0; resetn_s = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cancel = 1'b0;
    mul_a = '0; mul_b = '0; mul_signed = 1'b0;
    tick; tick;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mul_res", mul_res, 64'd0);
    resetn = 1'b1; resetn_s = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp);
      chk_lat($sformatf("vec%0d_lat", i), vecs[i].b, vecs[i].s, lat);
    end

    // Stalled consumer, then a back-to-back accept in DONE.
    mul_a = 32'd7; mul_b = 32'd9; mul_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    wait_done(lat);
    r0 = mul_res;
    chk("stall_res", r0, 64'd63);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("stall_stable", mul_res, 64'd63);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    mul_a = 32'd11; mul_b = 32'd13; mul_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    chk("b2b_no_idle", 64'(in_ready), 64'd0);
    chk("b2b_out_valid_low", 64'(out_valid), 64'd0);
    wait_done(lat);
    chk("b2b_res", mul_res, 64'd143);
    chk_lat("b2b_lat", 32'd13, 1'b0, lat);
    tick;

    // Cancel in CALC cycle 7, together with an in_valid that must be ignored.
    mul_a = 32'h1234_5678; mul_b = 32'h7654_3210; mul_signed = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    cancel = 1'b1; in_valid = 1'b1; mul_a = 32'd99; mul_b = 32'd99;
    #1;
    chk("cancel_in_ready", 64'(in_ready), 64'd0);
    tick;
    cancel = 1'b0; in_valid = 1'b0;
    #1;
    chk("cancel_in_ready_after", 64'(in_ready), 64'd1);
    chk("cancel_res_kept", mul_res, 64'd143);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    chk("cancel_no_out_valid", 64'(seen), 64'd0);
    run_op(32'd3, 32'd5, 1'b0, res, lat);
    chk("after_cancel_res", res, 64'd15);

    // Asynchronous reset in the middle of CALC.
    mul_a = 32'hDEAD_BEEF; mul_b = 32'h7BAD_F00D; mul_signed = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_mul_res", mul_res, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    tick;
    resetn = 1'b1;
    #1;
    chk("midrst_rel_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 10 == 0) rb = rb >> $urandom_range(0, 31);
      run_op(ra, rb, rs, res, lat);
      chk($sformatf("rand%0d_res a=%h b=%h s=%0d", i, ra, rb, rs), res, ref_prod(ra, rb, rs, 32));
      chk_lat($sformatf("rand%0d_lat", i), rb, rs, lat);
    end

    for (int i = 0; i < 20000 && !small_done; i++) tick;
    chk("small_width_done", 64'(small_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Random handshake traffic on the narrow instances. Handshakes are sampled
  // on the falling edge, before the rising edge at which they take effect.
  initial begin
    logic [63:0] q8[$];
    logic [63:0] q16[$];
    logic [63:0] e;
    int n8, n16;
    n8 = 0; n16 = 0;
    iv8 = 1'b0; or8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    iv16 = 1'b0; or16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
    @(posedge resetn_s);
    tick;
    for (int c = 0; c < 6000 && (n8 < 60 || n16 < 60); c++) begin
      iv8  = ($urandom_range(0, 3) != 0); or8  = ($urandom_range(0, 3) != 0);
      a8   = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1));
      iv16 = ($urandom_range(0, 3) != 0); or16 = ($urandom_range(0, 3) != 0);
      a16  = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ov8 && or8) begin
        chk("w8_expected_output", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("w8_res", 64'(r8), e);
          n8++;
        end
      end
      if (iv8 && ir8) q8.push_back(ref_prod(32'(a8), 32'(b8), s8, 8));
      if (ov16 && or16) begin
        chk("w16_expected_output", 64'(q16.size() > 0), 64'd1);
        if (q16.size() > 0) begin
          e = q16.pop_front();
          chk("w16_res", 64'(r16), e);
          n16++;
        end
      end
      if (iv16 && ir16) q16.push_back(ref_prod(32'(a16), 32'(b16), s16, 16));
      tick;
    end
    chk("w8_count", 64'(n8 >= 60), 64'd1);
    chk("w16_count", 64'(n16 >= 60), 64'd1);
    small_done = 1'b1;
  end

endmodule
